// File: rtl/smi_mem_lib_write_burst_test_gen64_if.sv
// Channel bundle for the write burst test generator.
// master: the generator's view (takes descriptors, drives write requests/payload).
// slave : the environment's view (test sequencer plus write burst controller).
interface smi_mem_lib_write_burst_test_gen64_if;
  // test descriptor channel
  logic        testParamsValid;
  logic [63:0] testParamBurstAddr;
  logic [31:0] testParamBurstLen;
  logic [7:0]  testParamBurstOpts;
  logic [63:0] testParamDataInit;
  logic [63:0] testParamDataIncr;
  logic        testParamsStop;
  // test completion channel
  logic        testDoneValid;
  logic        testDoneStatusOk;
  logic        testDoneStop;
  // write burst request channel
  logic        writeParamsValid;
  logic [63:0] writeParamBurstAddr;
  logic [31:0] writeParamBurstLen;
  logic [7:0]  writeParamBurstOpts;
  logic        writeParamsStop;
  // write payload channel
  logic        writeDataValid;
  logic [63:0] writeDataValue;
  logic        writeDataStop;
  // controller completion channel
  logic        writeDoneValid;
  logic        writeDoneStatusOk;
  logic        writeDoneStop;

  modport master (
    input  testParamsValid, testParamBurstAddr, testParamBurstLen, testParamBurstOpts,
    input  testParamDataInit, testParamDataIncr,
    output testParamsStop,
    output testDoneValid, testDoneStatusOk,
    input  testDoneStop,
    output writeParamsValid, writeParamBurstAddr, writeParamBurstLen, writeParamBurstOpts,
    input  writeParamsStop,
    output writeDataValid, writeDataValue,
    input  writeDataStop,
    input  writeDoneValid, writeDoneStatusOk,
    output writeDoneStop
  );

  modport slave (
    output testParamsValid, testParamBurstAddr, testParamBurstLen, testParamBurstOpts,
    output testParamDataInit, testParamDataIncr,
    input  testParamsStop,
    input  testDoneValid, testDoneStatusOk,
    output testDoneStop,
    input  writeParamsValid, writeParamBurstAddr, writeParamBurstLen, writeParamBurstOpts,
    output writeParamsStop,
    input  writeDataValid, writeDataValue,
    output writeDataStop,
    output writeDoneValid, writeDoneStatusOk,
    input  writeDoneStop
  );
endinterface

// File: rtl/smi_mem_lib_write_burst_test_gen64.sv
// Write burst test generator: takes one test descriptor, issues a single write
// burst request, streams a 64-bit counting pattern (init + n*incr) as payload,
// then passes the controller's completion status straight through to the harness.
module smi_mem_lib_write_burst_test_gen64 (
  input  logic clk,
  input  logic srst,
  smi_mem_lib_write_burst_test_gen64_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_SET_PARAMS = 2'd1,
    S_SEND_DATA  = 2'd2,
    S_GET_STATUS = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [63:0] r_addr;
  logic [31:0] r_len;
  logic [7:0]  r_opts;
  logic [63:0] r_data;
  logic [63:0] r_incr;
  logic [31:0] r_remain;

  logic        w_req_xfer;
  logic        w_beat_xfer;
  logic        w_done_xfer;

  assign w_req_xfer  = (r_state == S_SET_PARAMS) && !bus.writeParamsStop;
  assign w_beat_xfer = (r_state == S_SEND_DATA)  && !bus.writeDataStop;
  assign w_done_xfer = (r_state == S_GET_STATUS) && bus.writeDoneValid && !bus.testDoneStop;

  // State register; reset abandons any burst in flight.
  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.testParamsValid) w_state_next = S_SET_PARAMS;
      end
      S_SET_PARAMS: begin
        // A zero-length burst has no payload phase; go straight to status.
        if (w_req_xfer) w_state_next = (r_remain != 32'd0) ? S_SEND_DATA : S_GET_STATUS;
      end
      S_SEND_DATA: begin
        if (w_beat_xfer && (r_remain == 32'd1)) w_state_next = S_GET_STATUS;
      end
      S_GET_STATUS: begin
        if (w_done_xfer) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Descriptor capture (continuously while idle, frozen afterwards) and beat counters.
  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      r_addr   <= '0;
      r_len    <= '0;
      r_opts   <= '0;
      r_data   <= '0;
      r_incr   <= '0;
      r_remain <= '0;
    end else begin
      if (r_state == S_IDLE) begin
        r_addr   <= bus.testParamBurstAddr;
        r_len    <= bus.testParamBurstLen;
        r_opts   <= bus.testParamBurstOpts;
        r_data   <= bus.testParamDataInit;
        r_incr   <= bus.testParamDataIncr;
        r_remain <= bus.testParamBurstLen;
      end else if (w_beat_xfer) begin
        // Data counter wraps modulo 2^64 by design.
        r_data   <= r_data + r_incr;
        r_remain <= r_remain - 32'd1;
      end
    end
  end

  // Output decode; completion status is a zero-latency pass-through in GetStatus.
  always_comb begin
    bus.testParamsStop      = (r_state != S_IDLE);
    bus.writeParamsValid    = (r_state == S_SET_PARAMS);
    bus.writeParamBurstAddr = r_addr;
    bus.writeParamBurstLen  = r_len;
    bus.writeParamBurstOpts = r_opts;
    bus.writeDataValid      = (r_state == S_SEND_DATA);
    bus.writeDataValue      = r_data;
    bus.testDoneValid       = 1'b0;
    bus.testDoneStatusOk    = 1'b0;
    // Hold off completions that arrive before the payload has been fully sent.
    bus.writeDoneStop       = 1'b1;
    if (r_state == S_GET_STATUS) begin
      bus.testDoneValid    = bus.writeDoneValid;
      bus.testDoneStatusOk = bus.writeDoneStatusOk;
      bus.writeDoneStop    = bus.testDoneStop;
    end
  end

endmodule

// File: tb/tb_smi_mem_lib_write_burst_test_gen64.sv
// Self-checking bench for the write burst test generator: table vectors,
// randomized descriptors against a counting-pattern reference model, and
// hand-written reset-abort sequences.
module tb_smi_mem_lib_write_burst_test_gen64;

  logic clk  = 1'b0;
  logic srst = 1'b1;

  always #5 clk = ~clk;

  smi_mem_lib_write_burst_test_gen64_if bus ();

  smi_mem_lib_write_burst_test_gen64 dut (
    .clk  (clk),
    .srst (srst),
    .bus  (bus)
  );

  typedef struct {
    logic [63:0] addr;
    logic [31:0] len;
    logic [7:0]  opts;
    logic [63:0] init;
    logic [63:0] incr;
    bit          ok;
    bit          early;
    int          pstop;
    int          dmode;
    int          dstop;
    logic [63:0] exp_last;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.testParamsValid    = 1'b0;
    bus.testParamBurstAddr = '0;
    bus.testParamBurstLen  = '0;
    bus.testParamBurstOpts = '0;
    bus.testParamDataInit  = '0;
    bus.testParamDataIncr  = '0;
    bus.testDoneStop       = 1'b0;
    bus.writeParamsStop    = 1'b0;
    bus.writeDataStop      = 1'b0;
    bus.writeDoneValid     = 1'b0;
    bus.writeDoneStatusOk  = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_params_stop"}, 64'(bus.testParamsStop), 64'd0);
    chk({tag, "_req_valid"},   64'(bus.writeParamsValid), 64'd0);
    chk({tag, "_data_valid"},  64'(bus.writeDataValid), 64'd0);
    chk({tag, "_data_value"},  bus.writeDataValue, 64'd0);
    chk({tag, "_addr"},        bus.writeParamBurstAddr, 64'd0);
    chk({tag, "_len"},         64'(bus.writeParamBurstLen), 64'd0);
    chk({tag, "_opts"},        64'(bus.writeParamBurstOpts), 64'd0);
    chk({tag, "_done_valid"},  64'(bus.testDoneValid), 64'd0);
    chk({tag, "_wdone_stop"},  64'(bus.writeDoneStop), 64'd1);
  endtask

  // Runs one full test. Must be entered at a negedge while the DUT is idle;
  // returns at the negedge right after the completion handshake.
  task automatic run_vec(input vec_t v, input int id);
    logic [31:0] beats;
    logic [63:0] last;
    int          reqs;
    int          pcnt;
    int          dcnt;
    int          cyc;
    bit          dv;
    bit          got_all;
    bit          in_send;
    bit          done;
    bit          req_now;
    beats = '0; last = '0; reqs = 0; pcnt = v.pstop; dcnt = v.dstop;
    cyc = 0; dv = 1'b0; done = 1'b0;

    bus.testParamBurstAddr = v.addr;
    bus.testParamBurstLen  = v.len;
    bus.testParamBurstOpts = v.opts;
    bus.testParamDataInit  = v.init;
    bus.testParamDataIncr  = v.incr;
    bus.testParamsValid    = 1'b1;
    #1;
    chk("desc_accept_stop", 64'(bus.testParamsStop), 64'd0);
    @(posedge clk);
    @(negedge clk);
    // Scramble the descriptor after acceptance: the request must stay frozen.
    bus.testParamsValid    = 1'b0;
    bus.testParamBurstAddr = {$urandom, $urandom};
    bus.testParamBurstLen  = $urandom;
    bus.testParamBurstOpts = 8'($urandom);
    bus.testParamDataInit  = {$urandom, $urandom};
    bus.testParamDataIncr  = {$urandom, $urandom};

    while (!done && cyc < 4000) begin
      got_all = (reqs == 1) && (beats == v.len);
      in_send = (reqs == 1) && !got_all;
      bus.writeParamsStop = (reqs == 0) && (pcnt > 0);
      if (reqs == 0 && pcnt > 0) pcnt--;
      case (v.dmode)
        1:       bus.writeDataStop = 1'(cyc & 1);
        2:       bus.writeDataStop = 1'($urandom_range(0, 1));
        default: bus.writeDataStop = 1'b0;
      endcase
      // Controller model: raises completion once the burst is in (or early), holds until taken.
      if (!dv && (got_all || (v.early && beats != 0))) dv = 1'b1;
      bus.writeDoneValid    = dv;
      bus.writeDoneStatusOk = dv ? v.ok : 1'($urandom);
      bus.testDoneStop      = got_all && (dcnt > 0);
      if (got_all && dcnt > 0) dcnt--;
      #1;
      chk("busy_params_stop", 64'(bus.testParamsStop), 64'd1);
      chk("req_valid", 64'(bus.writeParamsValid), 64'(reqs == 0));
      req_now = 1'b0;
      if (bus.writeParamsValid) begin
        chk("req_addr", bus.writeParamBurstAddr, v.addr);
        chk("req_len",  64'(bus.writeParamBurstLen), 64'(v.len));
        chk("req_opts", 64'(bus.writeParamBurstOpts), 64'(v.opts));
        req_now = !bus.writeParamsStop;
      end
      chk("data_valid", 64'(bus.writeDataValid), 64'(in_send));
      if (in_send && !bus.writeDataStop) begin
        chk("beat_value", bus.writeDataValue, v.init + 64'(beats) * v.incr);
        last  = bus.writeDataValue;
        beats = beats + 32'd1;
      end
      chk("done_valid", 64'(bus.testDoneValid), 64'(got_all && dv));
      chk("wdone_stop", 64'(bus.writeDoneStop), got_all ? 64'(bus.testDoneStop) : 64'd1);
      if (got_all && dv) chk("done_ok", 64'(bus.testDoneStatusOk), 64'(v.ok));
      if (got_all && dv && !bus.testDoneStop) done = 1'b1;
      if (req_now) reqs++;
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end

    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout vec %0d: got no completion after %0d cycles, required one", id, cyc);
    end
    idle_inputs();
    #1;
    chk("back_to_idle", 64'(bus.testParamsStop), 64'd0);
    chk("beats_total", 64'(beats), 64'(v.len));
    chk("req_count", 64'(reqs), 64'd1);
    if (v.len != 0) chk("last_beat", last, v.exp_last);
    $display("[TB] vec %0d addr=0x%0h len=%0d beats=%0d ok=%0d cycles=%0d",
             id, v.addr, v.len, beats, v.ok, cyc);
    @(negedge clk);
  endtask

  // Starts a burst, lets nb beats through, then pulses srst mid-cycle.
  task automatic abort_test(input logic [31:0] len, input logic [63:0] init,
                            input logic [63:0] incr, input int nb);
    idle_inputs();
    bus.testParamBurstAddr = 64'hA000;
    bus.testParamBurstLen  = len;
    bus.testParamBurstOpts = 8'h33;
    bus.testParamDataInit  = init;
    bus.testParamDataIncr  = incr;
    bus.testParamsValid    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.testParamsValid = 1'b0;
    #1;
    chk("abort_req_valid", 64'(bus.writeParamsValid), 64'd1);
    chk("abort_req_len", 64'(bus.writeParamBurstLen), 64'(len));
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < nb; i++) begin
      #1;
      chk("abort_beat_valid", 64'(bus.writeDataValid), 64'd1);
      chk("abort_beat_value", bus.writeDataValue, init + 64'(i) * incr);
      @(posedge clk);
      @(negedge clk);
    end
    #1;
    chk("abort_pre_valid", 64'(bus.writeDataValid), 64'd1);
    #1 srst = 1'b1;
    #1 check_reset_outputs("abort_async");
    @(posedge clk);
    #1 chk("abort_held_valid", 64'(bus.writeDataValid), 64'd0);
    @(negedge clk);
    srst = 1'b0;
    #1 check_reset_outputs("abort_release");
    $display("[TB] abort len=%0d after %0d beats", len, nb);
  endtask

  vec_t tbl [5];
  vec_t rv;

  initial begin
    idle_inputs();
    tbl[0] = '{64'h1000, 32'd4, 8'h5A, 64'h10, 64'h8, 1'b1, 1'b0, 0, 0, 0, 64'h28};
    tbl[1] = '{64'h1000, 32'd4, 8'h5A, 64'h10, 64'h8, 1'b1, 1'b0, 3, 1, 0, 64'h28};
    tbl[2] = '{64'h2000, 32'd0, 8'h01, 64'h77, 64'h1, 1'b1, 1'b0, 1, 0, 0, 64'h0};
    tbl[3] = '{64'h3000, 32'd3, 8'h00, 64'hFFFF_FFFF_FFFF_FFFE, 64'h1, 1'b1, 1'b0, 0, 0, 0, 64'h0};
    tbl[4] = '{64'h4000, 32'd5, 8'hC3, 64'h0, 64'h3, 1'b0, 1'b1, 0, 2, 2, 64'hC};

    repeat (3) @(negedge clk);
    #1 check_reset_outputs("reset_held");
    @(negedge clk);
    srst = 1'b0;
    #1 check_reset_outputs("reset_released");
    @(negedge clk);

    for (int i = 0; i < 5; i++) run_vec(tbl[i], i);

    abort_test(32'd8, 64'd100, 64'd7, 2);
    run_vec(tbl[0], 100);
    abort_test(32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF0, 64'h9, 3);
    run_vec(tbl[4], 101);

    for (int i = 0; i < 25; i++) begin
      rv.addr  = {$urandom, $urandom};
      rv.len   = 32'($urandom_range(0, 12));
      rv.opts  = 8'($urandom);
      rv.init  = {$urandom, $urandom};
      rv.incr  = {$urandom, $urandom};
      rv.ok    = 1'($urandom_range(0, 1));
      rv.early = 1'($urandom_range(0, 1));
      rv.pstop = $urandom_range(0, 3);
      rv.dmode = $urandom_range(0, 2);
      rv.dstop = $urandom_range(0, 3);
      rv.exp_last = (rv.len == 0) ? 64'd0 : rv.init + 64'(rv.len - 32'd1) * rv.incr;
      run_vec(rv, 200 + i);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/smi_mem_lib_write_burst_test_gen64.md
# smi_mem_lib_write_burst_test_gen64

Memory access library write burst test generator, the write-side counterpart of the read burst test checker. Accepts a test descriptor, issues one write burst request to the write burst controller, streams a 64-bit counting sequence (init value plus fixed increment per beat) as burst payload, then forwards the controller's completion status to the test harness. Sits between the test sequencer and an SMI write burst controller. A subsequent read burst check over the same region verifies the written data.

## Interface
- Parameters: none; data path fixed at 64 bits.
- clk  in  1  system clock; all logic on rising edge.
- srst  in  1  asynchronous, active-high reset.
- testParamsValid  in  1  test descriptor valid.
- testParamBurstAddr  in  64  burst start byte address.
- testParamBurstLen  in  32  burst length in 64-bit beats.
- testParamBurstOpts  in  8  burst options, passed through unmodified.
- testParamDataInit  in  64  first data word.
- testParamDataIncr  in  64  per-beat data increment.
- testParamsStop  out  1  descriptor back-pressure.
- testDoneValid  out  1  test completion valid.
- testDoneStatusOk  out  1  completion status.
- testDoneStop  in  1  completion back-pressure.
- writeParamsValid  out  1  burst request valid.
- writeParamBurstAddr  out  64  registered burst address.
- writeParamBurstLen  out  32  registered burst length.
- writeParamBurstOpts  out  8  registered burst options.
- writeParamsStop  in  1  request back-pressure.
- writeDataValid  out  1  payload beat valid.
- writeDataValue  out  64  payload beat value.
- writeDataStop  in  1  payload back-pressure.
- writeDoneValid  in  1  controller completion valid.
- writeDoneStatusOk  in  1  controller completion status.
- writeDoneStop  out  1  controller completion back-pressure.

## Operation
- Handshake on every channel: transfer occurs in a cycle with valid=1 and stop=0.
- Idle: testParamsStop=0; all descriptor fields, plus remaining-beat counter (=testParamBurstLen), captured every cycle. On testParamsValid go to SetParams.
- SetParams: writeParamsValid=1. On ~writeParamsStop: go to SendData if burstLen≠0, else directly to GetStatus.
- SendData: writeDataValid=1, writeDataValue=data counter. Per transfer: data counter += increment (modulo 2^64, wraps silently); remaining counter −1. Transfer with remaining==1 moves to GetStatus. No data transfer permitted in any other state.
- GetStatus: testDoneValid=writeDoneValid; writeDoneStop=testDoneStop; testDoneStatusOk=writeDoneStatusOk. On writeDoneValid & ~testDoneStop go to Idle.
- Outside GetStatus: writeDoneStop=1, testDoneValid=0; an early writeDoneValid (e.g. during SendData) is held off, not dropped.
- testParamsStop=1 in every state except Idle.
- Burst length 0xFFFFFFFF supported; remaining counter is 32-bit, no overflow.

## Timing
- Reset (async assert, sync-to-clk deassert by environment): state=Idle; all registers zero. Outputs during/after reset: testParamsStop=0, writeParamsValid=0, writeDataValid=0, writeDataValue=0, addr/len/opts=0, testDoneValid=0, writeDoneStop=1.
- Reset mid-burst: outputs return to reset values immediately (asynchronously); no further beats; burst is abandoned.
- Descriptor accepted cycle N → writeParamsValid high cycle N+1.
- Request accepted cycle M → first beat valid cycle M+1; one beat per cycle with writeDataStop=0.
- writeParam* outputs are stable from SetParams until return to Idle.
- Done status is combinational pass-through: zero added latency.
- Back-to-back: Idle reached cycle K; next descriptor can be accepted in cycle K.

## Test plan
- Addr 0x1000, len 4, init 0x10, incr 0x8, no stalls → one request (0x1000, 4, opts); beats 0x10, 0x18, 0x20, 0x28 on consecutive cycles; writeDone ok=1 → testDoneValid with ok=1.
- Same test with writeDataStop toggling every other cycle and writeParamsStop high 3 cycles → identical beat sequence, no duplicates or drops; request held stable while stalled.
- Len 0 → request issued, no writeDataValid ever, status forwarded directly.
- Init 0xFFFFFFFFFFFFFFFE, incr 1, len 3 → beats ...FE, ...FF, 0x0.
- writeDoneValid asserted early during SendData, ok=0; testDoneStop high 2 cycles in GetStatus → writeDoneStop=1 until GetStatus, testDoneValid held, ok=0 forwarded, Idle one cycle after testDoneStop falls.
- srst pulsed after 2 of 8 beats → writeDataValid=0 at once, state Idle, new descriptor then runs to completion normally.
